object_draw_sequencer: RTL and testbench
========================================

OBJECT_DRAW_SEQUENCER -- requirements
Module: object_draw_sequencer

Interface
REQ-001 Parameter NUM_OBJECTS, default 12, number of object slots scanned per frame (1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 4095, maximum cycles spent waiting for draw_object_done per object.
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 start_frame  input  1  request to draw one full frame of objects; sampled only in S_IDLE.
REQ-006 initial_frame  input  1  level; sampled with start_frame, marks the first frame after game load.
REQ-007 object_valid  input  NUM_OBJECTS  per-slot present mask, bit i = slot i; sampled with start_frame.
REQ-008 draw_object_done  input  1  drawer completion flag; held high by the drawer while start_draw_object is high.
REQ-009 start_draw_object  output  1  request to the drawer for the current slot.
REQ-010 object_location_address  output  4  current slot index.
REQ-011 start_initial_module  output  1  high for the whole of an initial frame, so the drawer stores object locations.
REQ-012 busy  output  1  high in every state except S_IDLE.
REQ-013 frame_done  output  1  one-cycle pulse at the end of a frame.
REQ-014 timeout_error  output  1  sticky flag, set on any handshake timeout.

Function
REQ-015 States: S_IDLE, S_SCAN, S_REQUEST, S_RELEASE, S_FRAME_DONE; next-state and outputs decoded from the registered state.
REQ-016 S_IDLE: on start_frame=1, latch object_valid and initial_frame, clear address to 0, go to S_SCAN; otherwise stay.
REQ-017 S_SCAN (one slot per cycle) has three exits.
REQ-017a If the address equals NUM_OBJECTS, go to S_FRAME_DONE.
REQ-017b Else, if the slot is eligible, go to S_REQUEST.
REQ-017c Else, increment the address and stay in S_SCAN.
REQ-018 Eligible means the latched valid bit is 1, or the latched initial flag is 1 (an initial frame draws every slot).
REQ-019 S_REQUEST: start_draw_object=1; the timeout counter increments each cycle.
REQ-019a On draw_object_done=1, go to S_RELEASE.
REQ-019b On counter==TIMEOUT_CYCLES, set timeout_error and go to S_RELEASE.
REQ-020 S_RELEASE: start_draw_object=0; wait until draw_object_done=0, then increment the address, clear the counter and go to S_SCAN; no timeout applies here.
REQ-021 S_FRAME_DONE: frame_done=1 for one cycle, clear the latched initial flag, go to S_IDLE.
REQ-022 start_frame outside S_IDLE is ignored and not queued; object_valid changes mid-frame have no effect.
REQ-023 object_location_address is stable for the whole S_REQUEST/S_RELEASE visit of a slot.
REQ-024 The address never exceeds NUM_OBJECTS; the 4-bit width needs NUM_OBJECTS ≤ 15.
REQ-025 The timeout counter is 12 bits and saturates.
REQ-026 timeout_error clears only on reset.
REQ-027 Simultaneous draw_object_done=1 and counter==TIMEOUT_CYCLES: treated as done; timeout_error is not set.

Reset
REQ-028 With resetn=0 at a rising edge, the block enters S_IDLE, even mid-handshake.
REQ-029 Reset clears: address, counter, latched mask, latched initial flag and timeout_error.
REQ-030 During and after reset all outputs are 0: start_draw_object, busy, frame_done, start_initial_module, timeout_error and object_location_address.

Structure
REQ-031 Shared package draw_pkg holds the state encoding, NUM_OBJECTS_DEFAULT=12 and TIMEOUT_DEFAULT=4095, shared with the drawer control.
REQ-032 One sub-module, handshake_watchdog, implements the 12-bit saturating counter with enable, clear and expired outputs.

Verification
REQ-033 Reset mid-S_REQUEST → the next cycle is S_IDLE with all outputs 0.
REQ-034 object_valid=0, initial=0, start_frame pulse → no start_draw_object; frame_done rises at the 14th rising edge after start_frame is sampled.
REQ-035 object_valid=12'h005, drawer model answers done 3 cycles after start and drops it 1 cycle after start falls → start_draw_object only at addresses 0 and 2, then one frame_done pulse.
REQ-036 initial=1, object_valid=0 → all 12 slots requested, start_initial_module high throughout, then low after frame_done.
REQ-037 Drawer never answers → start_draw_object falls after 4095 request cycles, timeout_error=1, and the sequence continues to the next slot.
REQ-038 start_frame held high through a whole frame → exactly one frame per entry to S_IDLE, and address/valid changes mid-frame are ignored.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the object draw sequencer and the drawer control:
// state encoding, default sizes and the slot eligibility rule.
package draw_pkg;

   localparam int NUM_OBJECTS_DEFAULT = 12;
   localparam int TIMEOUT_DEFAULT     = 4095;
   localparam int ADDR_W              = 4;
   localparam int COUNT_W             = 12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_REQUEST,
      S_RELEASE,
      S_FRAME_DONE
   } draw_state_t;

   // An initial frame draws every slot so the drawer can record all locations.
   function automatic logic slot_eligible(input logic [(1 << ADDR_W)-1:0] valid_mask,
                                          input logic                     initial_flag,
                                          input logic [ADDR_W-1:0]        slot);
      return valid_mask[slot] | initial_flag;
   endfunction

endpackage

// File: rtl/object_draw_sequencer_if.sv
// Request/acknowledge handshake between the object draw sequencer and the drawer.
interface object_draw_sequencer_if;
   import draw_pkg::*;

   logic              start_draw_object;
   logic              draw_object_done;
   logic [ADDR_W-1:0] object_location_address;
   logic              start_initial_module;

   modport master (
      output start_draw_object,
      output object_location_address,
      output start_initial_module,
      input  draw_object_done
   );

   modport slave (
      input  start_draw_object,
      input  object_location_address,
      input  start_initial_module,
      output draw_object_done
   );

endinterface

// File: rtl/handshake_watchdog.sv
// Saturating cycle counter that flags the LIMIT-th enabled cycle since the last clear.
module handshake_watchdog
   import draw_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_DEFAULT
) (
   input  logic clock,
   input  logic resetn,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam logic [COUNT_W:0] LAST_COUNT = (COUNT_W+1)'(LIMIT - 1);

   logic [COUNT_W-1:0] count;

   always_ff @(posedge clock) begin
      if (!resetn || clear) begin
         count <= '0;
      end else if (enable && (count != {COUNT_W{1'b1}})) begin
         count <= count + COUNT_W'(1);
      end
   end

   // count holds the number of earlier enabled cycles, so this fires on the LIMIT-th one.
   assign expired = enable && ({1'b0, count} == LAST_COUNT);

endmodule

// File: rtl/object_draw_sequencer.sv
// Walks the object slots once per frame and hands each eligible slot to the
// drawer through a request/acknowledge handshake guarded by a watchdog.
module object_draw_sequencer
   import draw_pkg::*;
#(
   parameter int NUM_OBJECTS    = NUM_OBJECTS_DEFAULT,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   start_frame,
   input  logic                   initial_frame,
   input  logic [NUM_OBJECTS-1:0] object_valid,
   object_draw_sequencer_if.master bus,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   timeout_error
);

   draw_state_t                 state;
   logic [ADDR_W-1:0]           address;
   logic [(1 << ADDR_W)-1:0]    valid_latched;
   logic                        initial_latched;
   logic                        start_draw_q;
   logic                        start_initial_q;
   logic                        watchdog_expired;

   handshake_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock   (clock),
      .resetn  (resetn),
      .enable  (state == S_REQUEST),
      .clear   (state != S_REQUEST),
      .expired (watchdog_expired)
   );

   assign bus.start_draw_object       = start_draw_q;
   assign bus.object_location_address = address;
   assign bus.start_initial_module    = start_initial_q;

   // Outputs are registered alongside the state so they change only with it;
   // done takes priority over an expiry landing in the same cycle.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state           <= S_IDLE;
         address         <= '0;
         valid_latched   <= '0;
         initial_latched <= 1'b0;
         start_draw_q    <= 1'b0;
         start_initial_q <= 1'b0;
         busy            <= 1'b0;
         frame_done      <= 1'b0;
         timeout_error   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_frame) begin
                  valid_latched   <= (1 << ADDR_W)'(object_valid);
                  initial_latched <= initial_frame;
                  start_initial_q <= initial_frame;
                  address         <= '0;
                  busy            <= 1'b1;
                  state           <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (address == ADDR_W'(NUM_OBJECTS)) begin
                  frame_done <= 1'b1;
                  state      <= S_FRAME_DONE;
               end else if (slot_eligible(valid_latched, initial_latched, address)) begin
                  start_draw_q <= 1'b1;
                  state        <= S_REQUEST;
               end else begin
                  address <= address + ADDR_W'(1);
               end
            end
            S_REQUEST: begin
               if (bus.draw_object_done) begin
                  start_draw_q <= 1'b0;
                  state        <= S_RELEASE;
               end else if (watchdog_expired) begin
                  timeout_error <= 1'b1;
                  start_draw_q  <= 1'b0;
                  state         <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (!bus.draw_object_done) begin
                  address <= address + ADDR_W'(1);
                  state   <= S_SCAN;
               end
            end
            S_FRAME_DONE: begin
               initial_latched <= 1'b0;
               start_initial_q <= 1'b0;
               busy            <= 1'b0;
               state           <= S_IDLE;
            end
            default: begin
               start_draw_q    <= 1'b0;
               start_initial_q <= 1'b0;
               busy            <= 1'b0;
               state           <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_object_draw_sequencer.sv
// Directed bench for object_draw_sequencer with a simple drawer model driving the handshake.
module tb_object_draw_sequencer;

   logic        clock;
   logic        resetn;
   logic        start_frame;
   logic        initial_frame;
   logic [11:0] object_valid;
   logic        busy;
   logic        frame_done;
   logic        timeout_error;

   object_draw_sequencer_if bus ();

   object_draw_sequencer dut (
      .clock         (clock),
      .resetn        (resetn),
      .start_frame   (start_frame),
      .initial_frame (initial_frame),
      .object_valid  (object_valid),
      .bus           (bus),
      .busy          (busy),
      .frame_done    (frame_done),
      .timeout_error (timeout_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          n_compared;
   int          n_mismatched;
   int          cyc;
   int          frame_done_cycle;
   int          req_events;
   int          req_len [16];
   logic [15:0] req_mask;
   bit          addr_unstable;
   bit          initial_wrong;

   task automatic apply_reset();
      resetn = 1'b0;
      start_frame = 1'b0;
      bus.draw_object_done = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

   // Starts a frame (cyc 1 is the edge sampling start_frame) and plays the drawer:
   // done rises once start has been seen for answer_delay cycles (never for silent_slot)
   // and drops as soon as start is seen low.
   task automatic drive_frame(input logic init, input logic [11:0] valid,
                              input logic [11:0] valid_mid, input int answer_delay,
                              input int silent_slot, input logic hold_start);
      int hi_cnt;
      int cur_addr;
      hi_cnt = 0;
      cur_addr = -1;
      cyc = 0;
      req_mask = '0;
      req_events = 0;
      frame_done_cycle = -1;
      addr_unstable = 1'b0;
      initial_wrong = 1'b0;
      for (int i = 0; i < 16; i++) req_len[i] = 0;
      initial_frame = init;
      object_valid = valid;
      start_frame = 1'b1;
      while (frame_done_cycle < 0 && cyc < 20000) begin
         @(posedge clock);
         #1;
         cyc++;
         if (!hold_start) start_frame = 1'b0;
         if (cyc == 3) object_valid = valid_mid;
         if (hi_cnt > 0 && (bus.start_draw_object || bus.draw_object_done) &&
             int'(bus.object_location_address) != cur_addr) addr_unstable = 1'b1;
         if (bus.start_draw_object) begin
            if (hi_cnt == 0) begin
               cur_addr = int'(bus.object_location_address);
               req_mask[bus.object_location_address] = 1'b1;
               req_events++;
            end
            hi_cnt++;
            if (cur_addr != silent_slot && hi_cnt >= answer_delay) bus.draw_object_done = 1'b1;
         end else begin
            if (hi_cnt > 0) req_len[cur_addr] = hi_cnt;
            hi_cnt = 0;
            bus.draw_object_done = 1'b0;
         end
         if (busy && (bus.start_initial_module !== init)) initial_wrong = 1'b1;
         if (frame_done) frame_done_cycle = cyc;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      start_frame = 1'b1;
      initial_frame = 1'b1;
      object_valid = 12'hFFF;
      bus.draw_object_done = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_compared++; if (bus.start_draw_object !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_start_draw: got %b expected 0", bus.start_draw_object); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_compared++; if (frame_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
      n_compared++; if (bus.start_initial_module !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_initial_module: got %b expected 0", bus.start_initial_module); end
      n_compared++; if (timeout_error !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_timeout_error: got %b expected 0", timeout_error); end
      n_compared++; if (bus.object_location_address !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_address: got %0d expected 0", bus.object_location_address); end
      start_frame = 1'b0;
      initial_frame = 1'b0;
      resetn = 1'b1;
      @(posedge clock);
      #1;
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_idle_hold: got busy %b expected 0", busy); end
   endtask

   task automatic test_empty_frame();
      drive_frame(1'b0, 12'h000, 12'h000, 1, -1, 1'b0);
      n_compared++; if (frame_done_cycle != 14) begin n_mismatched++; $display("[TB] FAIL empty_done_edge: got %0d expected 14", frame_done_cycle); end
      n_compared++; if (req_events != 0) begin n_mismatched++; $display("[TB] FAIL empty_requests: got %0d expected 0", req_events); end
      @(posedge clock);
      #1;
      n_compared++; if (frame_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL empty_pulse_width: got %b expected 0", frame_done); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL empty_back_idle: got busy %b expected 0", busy); end
   endtask

   task automatic test_sparse_frame();
      drive_frame(1'b0, 12'h005, 12'h005, 3, -1, 1'b0);
      n_compared++; if (req_mask !== 16'h0005) begin n_mismatched++; $display("[TB] FAIL sparse_slots: got %h expected 0005", req_mask); end
      n_compared++; if (req_events != 2) begin n_mismatched++; $display("[TB] FAIL sparse_requests: got %0d expected 2", req_events); end
      n_compared++; if (addr_unstable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sparse_addr_stable: got %b expected 0", addr_unstable); end
      n_compared++; if (frame_done_cycle < 0) begin n_mismatched++; $display("[TB] FAIL sparse_frame_done: got %0d expected a pulse", frame_done_cycle); end
      n_compared++; if (timeout_error !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sparse_no_timeout: got %b expected 0", timeout_error); end
      @(posedge clock);
      #1;
      n_compared++; if (frame_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sparse_single_pulse: got %b expected 0", frame_done); end
   endtask

   task automatic test_initial_frame();
      drive_frame(1'b1, 12'h000, 12'h000, 2, -1, 1'b0);
      n_compared++; if (req_mask !== 16'h0FFF) begin n_mismatched++; $display("[TB] FAIL initial_slots: got %h expected 0fff", req_mask); end
      n_compared++; if (req_events != 12) begin n_mismatched++; $display("[TB] FAIL initial_requests: got %0d expected 12", req_events); end
      n_compared++; if (initial_wrong !== 1'b0) begin n_mismatched++; $display("[TB] FAIL initial_module_level: got dropout %b expected 0", initial_wrong); end
      @(posedge clock);
      #1;
      n_compared++; if (bus.start_initial_module !== 1'b0) begin n_mismatched++; $display("[TB] FAIL initial_module_after: got %b expected 0", bus.start_initial_module); end
   endtask

   task automatic test_done_at_expiry();
      apply_reset();
      drive_frame(1'b0, 12'h001, 12'h001, 4095, -1, 1'b0);
      n_compared++; if (req_len[0] != 4095) begin n_mismatched++; $display("[TB] FAIL tie_request_len: got %0d expected 4095", req_len[0]); end
      n_compared++; if (timeout_error !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tie_no_error: got %b expected 0", timeout_error); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_timeout();
      drive_frame(1'b0, 12'h003, 12'h003, 2, 0, 1'b0);
      n_compared++; if (req_len[0] != 4095) begin n_mismatched++; $display("[TB] FAIL timeout_request_len: got %0d expected 4095", req_len[0]); end
      n_compared++; if (timeout_error !== 1'b1) begin n_mismatched++; $display("[TB] FAIL timeout_flag: got %b expected 1", timeout_error); end
      n_compared++; if (req_mask !== 16'h0003) begin n_mismatched++; $display("[TB] FAIL timeout_continues: got %h expected 0003", req_mask); end
      n_compared++; if (frame_done_cycle < 0) begin n_mismatched++; $display("[TB] FAIL timeout_frame_done: got %0d expected a pulse", frame_done_cycle); end
      @(posedge clock);
      #1;
      n_compared++; if (timeout_error !== 1'b1) begin n_mismatched++; $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_error); end
   endtask

   task automatic test_back_to_back();
      drive_frame(1'b0, 12'h010, 12'h0FF, 1, -1, 1'b1);
      n_compared++; if (req_mask !== 16'h0010) begin n_mismatched++; $display("[TB] FAIL hold_slots: got %h expected 0010", req_mask); end
      n_compared++; if (frame_done_cycle != 16) begin n_mismatched++; $display("[TB] FAIL hold_done_edge: got %0d expected 16", frame_done_cycle); end
      @(posedge clock);
      #1;
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_idle_visit: got busy %b expected 0", busy); end
      @(posedge clock);
      #1;
      n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hold_restart: got busy %b expected 1", busy); end
      start_frame = 1'b0;
   endtask

   task automatic test_reset_mid_request();
      int waited;
      apply_reset();
      initial_frame = 1'b1;
      object_valid = 12'h001;
      start_frame = 1'b1;
      waited = 0;
      do begin
         @(posedge clock);
         #1;
         start_frame = 1'b0;
         waited++;
      end while (!bus.start_draw_object && waited < 50);
      n_compared++; if (bus.start_draw_object !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_reached_request: got %b expected 1", bus.start_draw_object); end
      resetn = 1'b0;
      @(posedge clock);
      #1;
      n_compared++; if (bus.start_draw_object !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_start_draw: got %b expected 0", bus.start_draw_object); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
      n_compared++; if (bus.start_initial_module !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_initial_module: got %b expected 0", bus.start_initial_module); end
      n_compared++; if (bus.object_location_address !== 4'd0) begin n_mismatched++; $display("[TB] FAIL midreset_address: got %0d expected 0", bus.object_location_address); end
      n_compared++; if (frame_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_frame_done: got %b expected 0", frame_done); end
      resetn = 1'b1;
      initial_frame = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_stays_idle: got busy %b expected 0", busy); end
   endtask

   initial begin
      n_compared = 0;
      n_mismatched = 0;
      resetn = 1'b0;
      start_frame = 1'b0;
      initial_frame = 1'b0;
      object_valid = 12'h000;
      bus.draw_object_done = 1'b0;
      test_reset();
      test_empty_frame();
      test_sparse_frame();
      test_initial_frame();
      test_done_at_expiry();
      test_timeout();
      test_back_to_back();
      test_reset_mid_request();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
